axi_leds_req_arbiter: RTL and testbench

- Shares the AXI4-Lite LED register slave (4 x 32-bit registers, byte offsets 0x0/0x4/0x8/0xC) between NUM_REQ independent on-chip requesters.
- Each requester issues a simple single-word read or write request.
- Block arbitrates round-robin, runs exactly one AXI4-Lite transaction at a time on its master port, and returns read data and response status to the winning requester.
- Sits between fabric control logic (buttons, sequencers, PS-side bridges) and the LED IP slave port.

---
 rtl/axi_leds_req_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_axi_leds_req_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_leds_req_arbiter.sv
// axi_leds_req_arbiter
//   Round-robin front end that lets NUM_REQ on-chip requesters share one
//   AXI4-Lite master port to the LED register slave. Exactly one single-word
//   read or write is in flight at a time; its completion status (and read
//   data) is returned to the requester that won arbitration.
//
// Ports
//   ACLK, ARESET          clock (rising edge), asynchronous active-high reset
//   req_valid/req_write   per-requester request strobe (held until req_ready)
//                         and direction (1 = write)
//   req_addr/req_wdata    packed per-requester address / write data
//   req_ready             one-cycle accept pulse to the granted requester
//   rsp_valid             one-cycle completion pulse to the owning requester
//   rsp_rdata/rsp_err     shared read data / non-OKAY response flag
//   busy                  high whenever a transaction is being handled
//   M_AXI_*               AXI4-Lite master (AW, W, B, AR, R channels)
module axi_leds_req_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          busy,
  output logic [ADDR_WIDTH-1:0]         M_AXI_AWADDR,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]         M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]       M_AXI_WSTRB,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]         M_AXI_ARADDR,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]         M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_RSP
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;

  // Round-robin search: rotate the request vector so the priority pointer
  // sits at bit 0, pick the lowest set bit, then rotate the index back.
  logic [2*NUM_REQ-1:0]    req_dbl;
  logic [NUM_REQ-1:0]      req_rot;
  logic                    grant_found;
  logic [IDX_W-1:0]        grant_idx;
  logic [IDX_W:0]          grant_sum;
  logic [IDX_W:0]          ptr_inc;

  assign req_dbl = {req_valid, req_valid};
  assign req_rot = NUM_REQ'(req_dbl >> ptr_q);

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_sum   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        grant_found = 1'b1;
        grant_sum   = {1'b0, ptr_q} + (IDX_W+1)'(k);
        grant_idx   = (grant_sum >= NUM_REQ_W) ? IDX_W'(grant_sum - NUM_REQ_W)
                                               : IDX_W'(grant_sum);
      end
    end
  end

  assign ptr_inc = {1'b0, grant_idx} + (IDX_W+1)'(1);

  // Mux out the winner's request fields.
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_write;

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == IDX_W'(k)) begin
        sel_addr  = req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[k*DATA_WIDTH +: DATA_WIDTH];
        sel_write = req_write[k];
      end
    end
  end

  logic awvalid, wvalid, bready, arvalid, rready;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|req_valid) state_d = S_ARB;
      end
      S_ARB: begin
        // A requester that withdrew before ARB simply gets no grant.
        if (grant_found) begin
          owner_d   = grant_idx;
          addr_d    = sel_addr;
          wdata_d   = sel_wdata;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          ptr_d     = (ptr_inc == NUM_REQ_W) ? '0 : IDX_W'(ptr_inc);
          state_d   = sel_write ? S_WR : S_RD_ADDR;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_WR: begin
        // AW and W complete independently; each VALID drops the cycle
        // after its own handshake.
        awvalid   = !aw_done_q;
        wvalid    = !w_done_q;
        aw_done_d = aw_done_q | M_AXI_AWREADY;
        w_done_d  = w_done_q  | M_AXI_WREADY;
        if (aw_done_d && w_done_d) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        bready = 1'b1;
        if (M_AXI_BVALID) begin
          err_d   = (M_AXI_BRESP != 2'b00);
          state_d = S_RSP;
        end
      end
      S_RD_ADDR: begin
        arvalid = 1'b1;
        if (M_AXI_ARREADY) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        rready = 1'b1;
        if (M_AXI_RVALID) begin
          rdata_d = M_AXI_RDATA;
          err_d   = (M_AXI_RRESP != 2'b00);
          state_d = S_RSP;
        end
      end
      S_RSP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Per-requester strobes decoded from grant / owner index.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_strobe
    assign req_ready[gi] = (state_q == S_ARB) && grant_found &&
                           (grant_idx == IDX_W'(gi));
    assign rsp_valid[gi] = (state_q == S_RSP) && (owner_q == IDX_W'(gi));
  end

  // Registers are word-aligned; byte-lane bits are always driven low.
  assign M_AXI_AWADDR  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign M_AXI_ARADDR  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_AWVALID = awvalid;
  assign M_AXI_WVALID  = wvalid;
  assign M_AXI_BREADY  = bready;
  assign M_AXI_ARVALID = arvalid;
  assign M_AXI_RREADY  = rready;
  assign rsp_rdata     = rdata_q;
  assign rsp_err       = err_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_axi_leds_req_arbiter.sv
module tb_axi_leds_req_arbiter;

  localparam int N = 2;

  logic         ACLK;
  logic         ARESET;
  logic [N-1:0] req_valid, req_write, req_ready, rsp_valid;
  logic [N*4-1:0]  req_addr;
  logic [N*32-1:0] req_wdata;
  logic [31:0]  rsp_rdata;
  logic         rsp_err, busy;
  logic [3:0]   M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WSTRB;
  logic [2:0]   M_AXI_AWPROT, M_AXI_ARPROT;
  logic         M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [31:0]  M_AXI_WDATA, M_AXI_RDATA;
  logic [1:0]   M_AXI_BRESP, M_AXI_RRESP;
  logic         M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic         M_AXI_RVALID, M_AXI_RREADY;

  axi_leds_req_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // ---------------- AXI4-Lite slave model (4 x 32-bit registers) ----------
  int         aw_delay;
  logic [1:0] bresp_cfg, rresp_cfg;
  logic       r_stall;

  int          aw_cnt;
  logic        aw_got, w_got, ar_pend;
  logic [3:0]  s_awaddr, s_araddr;
  logic [31:0] s_wdata;
  logic [31:0] mem [4];
  logic        aw_hs, w_hs, ar_hs;
  logic [3:0]  wa, ra;
  logic [31:0] wd;

  assign M_AXI_AWREADY = (aw_cnt >= aw_delay);
  assign M_AXI_WREADY  = 1'b1;
  assign M_AXI_ARREADY = 1'b1;
  assign aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID & M_AXI_WREADY;
  assign ar_hs = M_AXI_ARVALID & M_AXI_ARREADY;
  assign wa = aw_hs ? M_AXI_AWADDR : s_awaddr;
  assign wd = w_hs ? M_AXI_WDATA : s_wdata;
  assign ra = ar_hs ? M_AXI_ARADDR : s_araddr;

  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0; ar_pend <= 1'b0;
      s_awaddr <= '0; s_araddr <= '0; s_wdata <= '0;
      M_AXI_BVALID <= 1'b0; M_AXI_BRESP <= 2'b00;
      M_AXI_RVALID <= 1'b0; M_AXI_RRESP <= 2'b00; M_AXI_RDATA <= '0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      if (aw_hs) aw_cnt <= 0;
      else if (M_AXI_AWVALID) aw_cnt <= aw_cnt + 1;
      if (aw_hs) s_awaddr <= M_AXI_AWADDR;
      if (w_hs) s_wdata <= M_AXI_WDATA;
      if ((aw_got || aw_hs) && (w_got || w_hs) && !M_AXI_BVALID) begin
        M_AXI_BVALID <= 1'b1;
        M_AXI_BRESP  <= bresp_cfg;
        if (bresp_cfg == 2'b00) mem[wa[3:2]] <= wd;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        aw_got <= aw_got | aw_hs;
        w_got  <= w_got | w_hs;
      end
      if (M_AXI_BVALID && M_AXI_BREADY) M_AXI_BVALID <= 1'b0;
      if (ar_hs) s_araddr <= M_AXI_ARADDR;
      if ((ar_hs || ar_pend) && !r_stall && !M_AXI_RVALID) begin
        M_AXI_RVALID <= 1'b1;
        M_AXI_RDATA  <= mem[ra[3:2]];
        M_AXI_RRESP  <= rresp_cfg;
        ar_pend      <= 1'b0;
      end else if (ar_hs) begin
        ar_pend <= 1'b1;
      end
      if (M_AXI_RVALID && M_AXI_RREADY) M_AXI_RVALID <= 1'b0;
    end
  end

  // ---------------- Bus monitor (samples on falling edge) -----------------
  int          mon_aw_hs, mon_w_hs, mon_ar_hs, mon_awv, mon_wv, mon_bready_early;
  int          mon_ready [N];
  logic [3:0]  last_awaddr, last_araddr, last_wstrb;
  logic [31:0] last_wdata;

  initial begin
    mon_aw_hs = 0; mon_w_hs = 0; mon_ar_hs = 0; mon_awv = 0; mon_wv = 0;
    mon_bready_early = 0;
    for (int i = 0; i < N; i++) mon_ready[i] = 0;
    last_awaddr = '0; last_araddr = '0; last_wstrb = '0; last_wdata = '0;
  end

  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (aw_hs) begin mon_aw_hs++; last_awaddr = M_AXI_AWADDR; end
      if (w_hs) begin mon_w_hs++; last_wdata = M_AXI_WDATA; last_wstrb = M_AXI_WSTRB; end
      if (ar_hs) begin mon_ar_hs++; last_araddr = M_AXI_ARADDR; end
      if (M_AXI_AWVALID) mon_awv++;
      if (M_AXI_WVALID) mon_wv++;
      if (M_AXI_BREADY && (M_AXI_AWVALID || M_AXI_WVALID)) mon_bready_early++;
      for (int i = 0; i < N; i++) if (req_ready[i]) mon_ready[i]++;
    end
  end

  // ---------------- Checking ----------------------------------------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          r;
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    int          aw_dly;
    logic [1:0]  bresp;
    logic [1:0]  rresp;
    logic [3:0]  exp_axaddr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [9];
  vec_t v;
  int   lat, order [4], ngr, b_aw, b_w, b_ar, b_awv, b_wv, b_be, b_rdy;
  bit   seen, done;
  logic [31:0] got_rd;
  logic got_err;

  initial begin
    //            r wr addr  wdata          dly bresp  rresp  axaddr rdata          err lat
    vecs[0] = '{0, 1, 4'h4, 32'h000000A5, 0, 2'b00, 2'b00, 4'h4, 32'h00000000, 1'b0, 4};
    vecs[1] = '{1, 0, 4'h4, 32'h0,        0, 2'b00, 2'b00, 4'h4, 32'h000000A5, 1'b0, 4};
    vecs[2] = '{0, 1, 4'h7, 32'h0000005A, 0, 2'b10, 2'b00, 4'h4, 32'h000000A5, 1'b1, 4};
    vecs[3] = '{1, 0, 4'h4, 32'h0,        0, 2'b00, 2'b00, 4'h4, 32'h000000A5, 1'b0, 4};
    vecs[4] = '{1, 1, 4'hC, 32'hDEADBEEF, 3, 2'b00, 2'b00, 4'hC, 32'h000000A5, 1'b0, 7};
    vecs[5] = '{0, 0, 4'hE, 32'h0,        0, 2'b00, 2'b00, 4'hC, 32'hDEADBEEF, 1'b0, 4};
    vecs[6] = '{0, 0, 4'h0, 32'h0,        0, 2'b00, 2'b10, 4'h0, 32'h00000000, 1'b1, 4};
    vecs[7] = '{1, 1, 4'h8, 32'h12345678, 0, 2'b00, 2'b00, 4'h8, 32'h00000000, 1'b0, 4};
    vecs[8] = '{1, 0, 4'h8, 32'h0,        0, 2'b00, 2'b00, 4'h8, 32'h12345678, 1'b0, 4};

    aw_delay = 0; bresp_cfg = 2'b00; rresp_cfg = 2'b00; r_stall = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    ARESET = 1'b1;

    // Reset state
    #3;
    chk("reset_outputs",
        {60'd0, busy, rsp_err, |req_ready, |rsp_valid}, 64'd0);
    chk("reset_axi_valid_ready",
        {59'd0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 64'd0);
    chk("reset_rdata", rsp_rdata, 64'd0);
    @(negedge ACLK); @(negedge ACLK);
    ARESET = 1'b0;

    // Contended round robin from reset: both held across four grants.
    b_rdy = mon_ready[0]; b_ar = mon_ready[1];
    @(negedge ACLK);
    req_valid = 2'b11; req_write = 2'b00;
    ngr = 0; done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge ACLK);
      if (req_ready != 2'b00 && ngr < 4) begin
        order[ngr] = req_ready[1] ? 1 : 0;
        ngr++;
      end else if (ngr == 4 && rsp_valid != 2'b00) begin
        req_valid = 2'b00;
        done = 1'b1;
      end
    end
    req_valid = 2'b00;
    chk("rr_grant_count", ngr, 4);
    chk("rr_order0", order[0], 0);
    chk("rr_order1", order[1], 1);
    chk("rr_order2", order[2], 0);
    chk("rr_order3", order[3], 1);
    chk("rr_ready_req0", mon_ready[0] - b_rdy, 2);
    chk("rr_ready_req1", mon_ready[1] - b_ar, 2);
    $display("txn rr: grants %0d %0d %0d %0d", order[0], order[1], order[2], order[3]);
    @(negedge ACLK);

    // Table-driven single transactions
    for (int t = 0; t < 9; t++) begin
      v = vecs[t];
      aw_delay = v.aw_dly; bresp_cfg = v.bresp; rresp_cfg = v.rresp;
      b_aw = mon_aw_hs; b_w = mon_w_hs; b_ar = mon_ar_hs;
      b_awv = mon_awv; b_wv = mon_wv; b_be = mon_bready_early; b_rdy = mon_ready[v.r];
      @(negedge ACLK);
      req_valid[v.r] = 1'b1;
      req_write[v.r] = v.wr;
      req_addr[v.r*4 +: 4] = v.addr;
      req_wdata[v.r*32 +: 32] = v.wdata;
      lat = -1; seen = 1'b0; got_rd = '0; got_err = 1'b0;
      for (int k = 1; k <= 60; k++) begin
        @(negedge ACLK);
        if (seen) req_valid[v.r] = 1'b0;
        if (req_ready[v.r]) seen = 1'b1;
        if (rsp_valid[v.r]) begin
          lat = k; got_rd = rsp_rdata; got_err = rsp_err;
          break;
        end
      end
      req_valid[v.r] = 1'b0;
      @(negedge ACLK);
      chk($sformatf("v%0d_rsp_one_cycle", t), {62'd0, rsp_valid}, 64'd0);
      chk($sformatf("v%0d_latency", t), lat, v.exp_lat);
      chk($sformatf("v%0d_rdata", t), got_rd, v.exp_rdata);
      chk($sformatf("v%0d_err", t), got_err, v.exp_err);
      chk($sformatf("v%0d_ready_pulses", t), mon_ready[v.r] - b_rdy, 1);
      if (v.wr) begin
        chk($sformatf("v%0d_aw_hs", t), mon_aw_hs - b_aw, 1);
        chk($sformatf("v%0d_w_hs", t), mon_w_hs - b_w, 1);
        chk($sformatf("v%0d_awaddr", t), last_awaddr, v.exp_axaddr);
        chk($sformatf("v%0d_wdata", t), last_wdata, v.wdata);
        chk($sformatf("v%0d_wstrb", t), last_wstrb, 4'hF);
        chk($sformatf("v%0d_awvalid_cycles", t), mon_awv - b_awv, v.aw_dly + 1);
        chk($sformatf("v%0d_wvalid_cycles", t), mon_wv - b_wv, 1);
        chk($sformatf("v%0d_bready_early", t), mon_bready_early - b_be, 0);
      end else begin
        chk($sformatf("v%0d_ar_hs", t), mon_ar_hs - b_ar, 1);
        chk($sformatf("v%0d_araddr", t), last_araddr, v.exp_axaddr);
        chk($sformatf("v%0d_no_write", t), mon_aw_hs - b_aw, 0);
      end
      $display("txn %0d: req%0d %s addr=%h lat=%0d rdata=%h err=%0b",
               t, v.r, v.wr ? "WR" : "RD", v.addr, lat, got_rd, got_err);
    end

    // Reset while waiting in RD_DATA; req0 granted so pointer would favour req1.
    aw_delay = 0; bresp_cfg = 2'b00; rresp_cfg = 2'b00; r_stall = 1'b1;
    @(negedge ACLK);
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[3:0] = 4'h4;
    seen = 1'b0; done = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge ACLK);
      if (seen) req_valid[0] = 1'b0;
      if (req_ready[0]) seen = 1'b1;
      if (M_AXI_RREADY) done = 1'b1;
    end
    chk("rst_reached_rd_data", done, 1);
    req_valid = 2'b00;
    ARESET = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rready", M_AXI_RREADY, 0);
    chk("rst_valids",
        {59'd0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, |rsp_valid}, 64'd0);
    chk("rst_rdata_cleared", rsp_rdata, 64'd0);
    @(negedge ACLK);
    ARESET = 1'b0; r_stall = 1'b0;
    req_valid = 2'b11; req_write = 2'b00;
    ngr = -1; done = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge ACLK);
      if (req_ready != 2'b00) begin
        ngr = req_ready[1] ? 1 : 0;
        done = 1'b1;
      end
    end
    chk("rst_first_grant_req0", ngr, 0);
    @(negedge ACLK);
    req_valid = 2'b00;
    done = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge ACLK);
      if (rsp_valid != 2'b00) done = 1'b1;
    end
    chk("rst_post_txn_done", done, 1);
    $display("txn rst: first grant after reset req%0d", ngr);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
